// File: rtl/mux_logic_reduce_pipe.sv
// mux_logic_reduce_pipe: pipelined OR/AND/XOR/NOR bit reduction built from 2:1 mux nodes, one register stage per tree level
module mux_logic_reduce_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [1:0]       out_op
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    logic [LEAVES-1:0] leaves;
    logic [LEAVES-1:0] nodes;
    logic [LEAVES-1:0] src_data [LEVELS];
    logic [1:0]        src_op   [LEVELS];
    logic [LEVELS-1:0] src_valid;
    logic [LEVELS:0]   ready;
    logic [LEAVES-1:0] data_d   [LEVELS];
    logic [LEAVES-1:0] data_q   [LEVELS];
    logic [1:0]        op_d     [LEVELS];
    logic [1:0]        op_q     [LEVELS];
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] valid_q;

    // NOR reduces as OR; the final stage applies the inversion
    function automatic logic node(input logic [1:0] op, input logic x, input logic y);
        return op == OP_AND ? (y ? x : 1'b0) : op == OP_XOR ? (y ? ~x : x) : (y ? 1'b1 : x);
    endfunction

    // pad leaves with the op identity, build every tree level and the per-stage handshake
    always_comb begin
        leaves = {LEAVES{in_op == OP_AND}};
        leaves[WIDTH-1:0] = in_data;
        nodes = '0;
        src_data[0] = leaves;
        src_op[0] = in_op;
        src_valid[0] = in_valid;
        for (int k = 1; k < LEVELS; k++) begin
            src_data[k] = data_q[k-1];
            src_op[k] = op_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
        ready[LEVELS] = out_ready;
        for (int k = 0; k < LEVELS; k++)
            ready[k] = out_ready || (((~valid_q) >> k) != '0);
        for (int k = 0; k < LEVELS; k++) begin
            nodes = '0;
            for (int i = 0; i < LEAVES / 2; i++)
                nodes[i] = node(src_op[k], src_data[k][2*i], src_data[k][2*i+1]);
            if (k == LEVELS - 1 && src_op[k] == OP_NOR)
                nodes[0] = ~nodes[0];
            data_d[k] = ready[k] ? nodes : data_q[k];
            op_d[k] = ready[k] ? src_op[k] : op_q[k];
            valid_d[k] = ready[k] ? src_valid[k] : valid_q[k];
        end
    end

    // stage registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                data_q[k] <= '0;
                op_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < LEVELS; k++) begin
                data_q[k] <= data_d[k];
                op_q[k] <= op_d[k];
            end
        end
    end

    assign in_ready = ready[0];
    assign out_valid = valid_q[LEVELS-1];
    assign out_bit = data_q[LEVELS-1][0];
    assign out_op = op_q[LEVELS-1];
endmodule
